// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D memory arbiter: block sizes, FSM encoding, owner ids
// and the round-robin pick helper.
package mem_arbiter_pkg;

  localparam int WORD_SIZE  = 8;
  localparam int BLOCK_SIZE = 1024;
  localparam int LAT_W      = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  // On a tie, serve whichever side did not finish most recently.
  function automatic owner_t rr_pick(input logic i_req, input logic d_req, input owner_t last);
    if (i_req && d_req) return (last == OWNER_I) ? OWNER_D : OWNER_I;
    return d_req ? OWNER_D : OWNER_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Client and memory-side bus of the arbiter. The slave modport is the arbiter's
// view; master is the view of the surrounding caches/memory.
interface mem_arbiter_if #(
  parameter int ADDR_W  = 8,
  parameter int BLOCK_W = 1024
);
  logic               i_req;
  logic [ADDR_W-1:0]  i_addr;
  logic               i_valid;
  logic [BLOCK_W-1:0] i_rdata;

  logic               d_req;
  logic               d_we;
  logic [ADDR_W-1:0]  d_addr;
  logic [BLOCK_W-1:0] d_wdata;
  logic               d_valid;
  logic [BLOCK_W-1:0] d_rdata;

  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_readable;
  logic               mem_writable;
  logic [BLOCK_W-1:0] mem_wdata;
  logic [BLOCK_W-1:0] mem_rdata;

  logic               busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_valid, i_rdata, d_valid, d_rdata,
    output mem_addr, mem_readable, mem_writable, mem_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_valid, i_rdata, d_valid, d_rdata,
    input  mem_addr, mem_readable, mem_writable, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter_lat_counter.sv
// mem_lat_counter: loadable down-counter that tracks the remaining memory
// access cycles; zero is combinational off the count.
module mem_lat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Serializes I-side and D-side block transfers onto the shared memory with a
// fixed MEM_LAT access time. `MEM_ARB_DATA_PRIO_EN selects D-wins-ties priority
// instead of round-robin.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = WORD_SIZE,
  parameter int BLOCK_W = BLOCK_SIZE,
  parameter int MEM_LAT = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

  arb_state_t         state_q, state_d;
  owner_t             owner_q, owner_d, grant;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               we_q, we_d;
  logic [BLOCK_W-1:0] wdata_q, wdata_d;
  logic               rd_q, rd_d, wr_q, wr_d;
  logic               i_valid_q, i_valid_d, d_valid_q, d_valid_d;
  logic [BLOCK_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic               busy_q, busy_d;
  logic               cnt_load, cnt_dec, cnt_zero;

`ifdef MEM_ARB_DATA_PRIO_EN
  always_comb grant = bus.d_req ? OWNER_D : OWNER_I;
`else
  owner_t rr_last_q, rr_last_d;
  always_comb grant = rr_pick(bus.i_req, bus.d_req, rr_last_q);
`endif

  mem_lat_counter #(.W(LAT_W)) u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (LAT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_valid_d = 1'b0;
    d_valid_d = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
`ifndef MEM_ARB_DATA_PRIO_EN
    rr_last_d = rr_last_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          owner_d  = grant;
          addr_d   = (grant == OWNER_D) ? bus.d_addr : bus.i_addr;
          we_d     = (grant == OWNER_D) && bus.d_we;
          wdata_d  = (grant == OWNER_D) ? bus.d_wdata : '0;
          rd_d     = !((grant == OWNER_D) && bus.d_we);
          wr_d     = (grant == OWNER_D) && bus.d_we;
          cnt_load = 1'b1;
          state_d  = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (cnt_zero) begin
          // mem_rdata is only guaranteed in this last access cycle
          if (!we_q) begin
            if (owner_q == OWNER_D) d_rdata_d = bus.mem_rdata;
            else                    i_rdata_d = bus.mem_rdata;
          end
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          i_valid_d = (owner_q == OWNER_I);
          d_valid_d = (owner_q == OWNER_D);
          state_d   = ARB_RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ARB_RESP: begin
`ifndef MEM_ARB_DATA_PRIO_EN
        rr_last_d = owner_q;
`endif
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWNER_I;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      i_valid_q <= i_valid_d;
      d_valid_q <= d_valid_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      busy_q    <= busy_d;
    end
  end

`ifndef MEM_ARB_DATA_PRIO_EN
  // Pointer at D after reset so the I side takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_last_q <= OWNER_D;
    else     rr_last_q <= rr_last_d;
  end
`endif

  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_readable = rd_q;
  assign bus.mem_writable = wr_q;
  assign bus.i_valid      = i_valid_q;
  assign bus.d_valid      = d_valid_q;
  assign bus.i_rdata      = i_rdata_q;
  assign bus.d_rdata      = d_rdata_q;
  assign bus.busy         = busy_q;

endmodule
